// File: rtl/mdu_seq_if.sv
// Request/result bundle between a requester and the sequential multiply/divide unit.
// The master drives the requests and the slave returns busy, done and the HI/LO registers.
interface mdu_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, A, B, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide unit with architectural HI/LO registers.
// MULTU and DIVU take one iteration per cycle, 32 iterations each. MTHI and MTLO write HI or LO directly.
module mdu_seq (
  input  logic    clk,
  input  logic    reset_n,
  mdu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic        q_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Multiply: add into the top half, then shift the accumulator right one bit.
    mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
    // Divide: a_q shifts the dividend out from its MSB and takes quotient bits in at its LSB.
    rem_sh  = {rem_q, a_q[31]};
    rem_sub = rem_sh - {1'b0, b_q};
    q_bit   = (rem_sh >= {1'b0, b_q});

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b00: begin
              a_d     = bus.A;
              b_d     = bus.B;
              acc_d   = '0;
              cnt_d   = 5'd31;
              state_d = MUL;
              busy_d  = 1'b1;
            end
            2'b01: begin
              a_d     = bus.A;
              b_d     = bus.B;
              rem_d   = '0;
              cnt_d   = 5'd31;
              state_d = DIV;
              busy_d  = 1'b1;
            end
            2'b10:   hi_d = bus.A;
            default: lo_d = bus.A;
          endcase
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        b_d   = {1'b0, b_q[31:1]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          {hi_d, lo_d} = {mul_sum, acc_q[31:1]};
          state_d      = IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end
      end
      DIV: begin
        rem_d = q_bit ? rem_sub[31:0] : rem_sh[31:0];
        a_d   = {a_q[30:0], q_bit};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          hi_d    = q_bit ? rem_sub[31:0] : rem_sh[31:0];
          lo_d    = {a_q[30:0], q_bit};
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
